// File: rtl/objeto_caida_pkg.sv
// Shared constants, state encoding and helpers for the falling-object game.
// Screen geometry is expressed in pixels of a 640x480 VGA frame.
package objeto_caida_pkg;

  localparam int MAX_X             = 640;
  localparam int MAX_Y             = 480;
  localparam int TAMANIO_CANASTA   = 90;
  localparam int TAMANIO_CANASTA_Y = 32;
  localparam int Y_CANASTA         = 447;
  localparam int FILA_REFRESCO     = 481;
  localparam int TAMANIO_OBJETO    = 16;

  // Top row the object must reach to rest on the basket rim.
  localparam int Y_ATRAPE        = Y_CANASTA - TAMANIO_OBJETO;
  localparam int FRAMES_ESPERA   = 29;
  localparam int X_MIN_OBJETO    = 56;
  localparam int VEL_INICIAL     = 2;
  localparam int VEL_MAXIMA      = 7;
  localparam int VIDAS_INICIALES = 3;
  localparam int PUNTAJE_MAXIMO  = 255;

  localparam logic [9:0] LFSR_SEMILLA = 10'h1A5;

  typedef enum logic [2:0] {
    ESPERA   = 3'd0,
    CAYENDO  = 3'd1,
    ATRAPADO = 3'd2,
    PERDIDO  = 3'd3,
    FIN      = 3'd4
  } estado_t;

  // Inclusive interval test: inicio <= v <= inicio + largo.
  function automatic logic en_intervalo(input logic [10:0] v,
                                        input logic [10:0] inicio,
                                        input logic [10:0] largo);
    return (v >= inicio) && (v <= inicio + largo);
  endfunction

endpackage

// File: rtl/objeto_caida_lfsr.sv
// Free-running 10-bit Fibonacci LFSR (taps 10 and 7) used to pick spawn columns.
// It advances on every clock so the spawn point depends on game timing.
module lfsr_aleatorio
  import objeto_caida_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] valor
);

  logic [9:0] lfsr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_reg <= LFSR_SEMILLA;
    end else begin
      lfsr_reg <= {lfsr_reg[8:0], lfsr_reg[9] ^ lfsr_reg[6]};
    end
  end

  assign valor = lfsr_reg;

endmodule

// File: rtl/objeto_caida.sv
// Falling-object game core: spawns a 16x16 object, drops it once per frame and
// scores a catch when it lands on the basket, or costs a life when it leaves the screen.
module objeto_caida
  import objeto_caida_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic [9:0] pos_x_canasta,
  output logic       pintar_objeto,
  output logic [7:0] puntaje,
  output logic [1:0] vidas,
  output logic       atrapado,
  output logic       fin_juego
);

  estado_t    estado_reg, estado_next;
  logic [4:0] contador_reg, contador_next;
  logic [9:0] obj_x_reg, obj_x_next;
  logic [9:0] obj_y_reg, obj_y_next;
  logic [2:0] vel_reg, vel_next;
  logic [7:0] puntaje_reg, puntaje_next;
  logic [1:0] vidas_reg, vidas_next;

  logic [9:0]  lfsr_valor;
  logic        tick_refresco;
  logic        solape;
  logic        visible;
  logic [10:0] obj_x_ext, obj_y_ext, canasta_ext, y_sig;
  logic [7:0]  puntaje_inc;

  lfsr_aleatorio u_lfsr (
    .clk   (clk),
    .reset (reset),
    .valor (lfsr_valor)
  );

  // One tick per frame, in the blanking interval just below the visible area.
  assign tick_refresco = (pixel_y == 10'(FILA_REFRESCO)) && (pixel_x == 10'd0);

  assign obj_x_ext   = {1'b0, obj_x_reg};
  assign obj_y_ext   = {1'b0, obj_y_reg};
  assign canasta_ext = {1'b0, pos_x_canasta};
  assign y_sig       = obj_y_ext + {8'd0, vel_reg};

  assign solape = (obj_x_ext + 11'(TAMANIO_OBJETO - 1) >= canasta_ext) &&
                  (obj_x_ext <= canasta_ext + 11'(TAMANIO_CANASTA));

  assign puntaje_inc = (puntaje_reg == 8'(PUNTAJE_MAXIMO)) ? puntaje_reg
                                                           : puntaje_reg + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_reg   <= ESPERA;
      contador_reg <= 5'd0;
      obj_x_reg    <= 10'd0;
      obj_y_reg    <= 10'd0;
      vel_reg      <= 3'(VEL_INICIAL);
      puntaje_reg  <= 8'd0;
      vidas_reg    <= 2'(VIDAS_INICIALES);
    end else begin
      estado_reg   <= estado_next;
      contador_reg <= contador_next;
      obj_x_reg    <= obj_x_next;
      obj_y_reg    <= obj_y_next;
      vel_reg      <= vel_next;
      puntaje_reg  <= puntaje_next;
      vidas_reg    <= vidas_next;
    end
  end

  always_comb begin
    estado_next   = estado_reg;
    contador_next = contador_reg;
    obj_x_next    = obj_x_reg;
    obj_y_next    = obj_y_reg;
    vel_next      = vel_reg;
    puntaje_next  = puntaje_reg;
    vidas_next    = vidas_reg;

    case (estado_reg)
      ESPERA: begin
        if (tick_refresco) begin
          if (contador_reg == 5'(FRAMES_ESPERA)) begin
            // Low nine LFSR bits keep the object fully on screen.
            obj_x_next    = 10'(X_MIN_OBJETO) + (lfsr_valor & 10'h1FF);
            obj_y_next    = 10'd0;
            contador_next = 5'd0;
            estado_next   = CAYENDO;
          end else begin
            contador_next = contador_reg + 5'd1;
          end
        end
      end

      CAYENDO: begin
        if (tick_refresco) begin
          // A catch is only possible on the frame the object crosses the rim.
          if ((obj_y_ext < 11'(Y_ATRAPE)) && (y_sig >= 11'(Y_ATRAPE)) && solape) begin
            obj_y_next  = 10'(Y_ATRAPE);
            estado_next = ATRAPADO;
          end else if (y_sig >= 11'(MAX_Y)) begin
            estado_next = PERDIDO;
          end else begin
            obj_y_next = y_sig[9:0];
          end
        end
      end

      ATRAPADO: begin
        puntaje_next = puntaje_inc;
        if ((puntaje_inc[1:0] == 2'd0) && (vel_reg < 3'(VEL_MAXIMA))) begin
          vel_next = vel_reg + 3'd1;
        end
        estado_next = ESPERA;
      end

      PERDIDO: begin
        vidas_next  = vidas_reg - 2'd1;
        estado_next = (vidas_reg == 2'd1) ? FIN : ESPERA;
      end

      FIN: begin
        estado_next = FIN;
      end

      default: begin
        estado_next = ESPERA;
      end
    endcase
  end

  assign visible = (estado_reg == CAYENDO) || (estado_reg == ATRAPADO);

  assign pintar_objeto = visible &&
      en_intervalo({1'b0, pixel_x}, obj_x_ext, 11'(TAMANIO_OBJETO - 1)) &&
      en_intervalo({1'b0, pixel_y}, obj_y_ext, 11'(TAMANIO_OBJETO - 1));

  assign atrapado  = (estado_reg == ATRAPADO);
  assign fin_juego = (estado_reg == FIN);
  assign puntaje   = puntaje_reg;
  assign vidas     = vidas_reg;

endmodule

// File: tb/tb_objeto_caida.sv
// Randomized bench for objeto_caida against a frame-level game model.
// The model tracks the game as plain integers and is stepped once per clock.
module tb_objeto_caida;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic [9:0] pos_x_canasta = '0;
  logic       pintar_objeto;
  logic [7:0] puntaje;
  logic [1:0] vidas;
  logic       atrapado;
  logic       fin_juego;

  objeto_caida dut (
    .clk           (clk),
    .reset         (reset),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .pos_x_canasta (pos_x_canasta),
    .pintar_objeto (pintar_objeto),
    .puntaje       (puntaje),
    .vidas         (vidas),
    .atrapado      (atrapado),
    .fin_juego     (fin_juego)
  );

  always #20 clk = ~clk;

  localparam int M_WAIT = 0, M_FALL = 1, M_CAUGHT = 2, M_LOST = 3, M_OVER = 4;
  localparam int P_CENTER = 0, P_EDGE_IN = 1, P_FAR = 2, P_EDGE_OUT_R = 3, P_EDGE_OUT_L = 4;

  int n_checks = 0;
  int n_errors = 0;

  int m_mode, m_cnt, m_x, m_y, m_vel, m_score, m_lives;
  logic [9:0] m_lfsr;
  bit   m_spawned;
  int   basket = 0;
  int   policy[$];
  int   pol_idx = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Game rules at frame granularity; one call per clock edge.
  task automatic model_step(input bit rst, input int px, input int py, input int bx);
    logic [9:0] l;
    bit tick;
    int ys;
    m_spawned = 0;
    if (rst) begin
      m_mode = M_WAIT; m_cnt = 0; m_x = 0; m_y = 0; m_vel = 2;
      m_score = 0; m_lives = 3; m_lfsr = 10'h1A5;
      return;
    end
    l = m_lfsr;
    m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    tick = (py == 481) && (px == 0);
    case (m_mode)
      M_WAIT: if (tick) begin
        if (m_cnt == 29) begin
          m_x = 56 + int'(l & 10'h1FF);
          m_y = 0; m_cnt = 0; m_mode = M_FALL; m_spawned = 1;
        end else m_cnt++;
      end
      M_FALL: if (tick) begin
        ys = m_y + m_vel;
        if (m_y < 431 && ys >= 431 && (m_x + 15 >= bx) && (m_x <= bx + 90)) begin
          m_y = 431; m_mode = M_CAUGHT;
        end else if (ys >= 480) m_mode = M_LOST;
        else m_y = ys;
      end
      M_CAUGHT: begin
        if (m_score < 255) m_score++;
        if (m_score % 4 == 0 && m_vel < 7) m_vel++;
        m_mode = M_WAIT;
      end
      M_LOST: begin
        m_lives--;
        m_mode = (m_lives == 0) ? M_OVER : M_WAIT;
      end
      default: ;
    endcase
  endtask

  function automatic int exp_paint(input int px, input int py);
    return int'((m_mode == M_FALL || m_mode == M_CAUGHT) &&
                px >= m_x && px <= m_x + 15 && py >= m_y && py <= m_y + 15);
  endfunction

  task automatic check_outputs();
    check("puntaje", int'(puntaje), m_score);
    check("vidas", int'(vidas), m_lives);
    check("atrapado", int'(atrapado), int'(m_mode == M_CAUGHT));
    check("fin_juego", int'(fin_juego), int'(m_mode == M_OVER));
    check("pintar", int'(pintar_objeto), exp_paint(int'(pixel_x), int'(pixel_y)));
  endtask

  task automatic probe(input string tag, input int px, input int py);
    pixel_x = 10'(px);
    pixel_y = 10'(py);
    #1;
    check(tag, int'(pintar_objeto), exp_paint(px, py));
  endtask

  function automatic int pick_basket(input int p, input int x);
    case (p)
      P_CENTER:     return x - 37;
      P_EDGE_IN:    return (x >= 90) ? x - 90 : x - 37;
      P_FAR:        return (x >= 200) ? 0 : 900;
      P_EDGE_OUT_R: return (x >= 91) ? x - 91 : x + 16;
      P_EDGE_OUT_L: return x + 16;
      default:      return x - 37;
    endcase
  endfunction

  task automatic run_cycle(input bit tk, input bit rst);
    int px, py;
    reset = rst;
    if (tk) begin
      pixel_x = 10'd0;
      pixel_y = 10'd481;
      pos_x_canasta = 10'(basket);
    end else begin
      if ((m_mode == M_FALL || m_mode == M_CAUGHT) && $urandom_range(0, 1) == 1) begin
        px = m_x - 1 + int'($urandom_range(0, 17));
        py = m_y - 1 + int'($urandom_range(0, 17));
        if (py < 0) py = 0;
      end else begin
        px = int'($urandom_range(0, 799));
        py = int'($urandom_range(0, 524));
      end
      if (px == 0 && py == 481) px = 5;
      pixel_x = 10'(px);
      pixel_y = 10'(py);
      pos_x_canasta = 10'($urandom_range(0, 1023));
    end
    @(posedge clk);
    model_step(rst, int'(pixel_x), int'(pixel_y), int'(pos_x_canasta));
    #1;
    check_outputs();
    if (m_spawned) begin
      probe("spawn_top_left", m_x, 0);
      probe("spawn_bottom_right", m_x + 15, 15);
      probe("spawn_right_out", m_x + 16, 0);
      probe("spawn_left_out", m_x - 1, 0);
      probe("spawn_below_out", m_x, 16);
      basket = (pol_idx < policy.size()) ? pick_basket(policy[pol_idx], m_x)
                                         : pick_basket(P_CENTER, m_x);
      $display("spawn %0d: obj_x=%0d vel=%0d basket=%0d", pol_idx, m_x, m_vel, basket);
      pol_idx++;
    end
  endtask

  task automatic run_frame();
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b0, 1'b0);
  endtask

  initial begin
    int sx, sy;
    bit ok;
    model_step(1'b1, 0, 0, 0);
    run_cycle(1'b0, 1'b1);
    run_cycle(1'b0, 1'b1);
    check("reset_puntaje", int'(puntaje), 0);
    check("reset_vidas", int'(vidas), 3);

    repeat (4) policy.push_back(P_CENTER);
    policy.push_back(P_EDGE_IN);
    policy.push_back(P_FAR);
    repeat (16) policy.push_back(P_CENTER);
    policy.push_back(P_EDGE_IN);
    policy.push_back(P_EDGE_OUT_R);
    policy.push_back(P_EDGE_OUT_L);

    for (int f = 0; f < 20000 && m_mode != M_OVER; f++) run_frame();
    check("game_over_fin_juego", int'(fin_juego), 1);
    check("game_over_puntaje", int'(puntaje), 22);
    check("game_over_vidas", int'(vidas), 0);

    repeat (40) run_frame();
    check("frozen_puntaje", int'(puntaje), 22);
    check("frozen_pintar", int'(pintar_objeto), 0);

    // Reset on the same edge as a refresh tick.
    run_cycle(1'b1, 1'b1);
    check("reset_tick_vidas", int'(vidas), 3);
    check("reset_tick_fin", int'(fin_juego), 0);

    ok = 0;
    for (int f = 0; f < 400 && !ok; f++) begin
      run_frame();
      ok = (m_mode == M_FALL && m_y >= 40);
    end
    check("mid_fall_reached", int'(pintar_objeto) | int'(ok), 1);
    sx = m_x;
    sy = m_y;
    probe("mid_fall_visible", sx, sy);
    run_cycle(1'b0, 1'b1);
    probe("reset_mid_fall", sx, sy);
    check("reset_mid_fall_raw", int'(pintar_objeto), 0);
    run_cycle(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/objeto_caida.md
OBJETO_CAIDA -- requirements
Module: objeto_caida

Interface
REQ-001 SHALL have port clk  input  1  system clock, 25 MHz pixel clock; all logic on its rising edge.
REQ-002 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-003 SHALL have ports pixel_x, pixel_y  input  10 each  current VGA scan coordinates.
REQ-004 SHALL have port pos_x_canasta  input  10  basket left edge (basket spans x..x+90, rows 447..479).
REQ-005 SHALL have port pintar_objeto  output  1  pixel lies inside the falling object.
REQ-006 SHALL have port puntaje  output  8  catch count.
REQ-007 SHALL have port vidas  output  2  remaining lives.
REQ-008 SHALL have port atrapado  output  1  one-clk pulse per catch.
REQ-009 SHALL have port fin_juego  output  1  high once lives reach 0.

Function
REQ-010 SHALL define refresh tick = (pixel_y == 481) && (pixel_x == 0); all position and state updates except reset and the one-clk states occur only on this tick.
REQ-011 SHALL model a 16x16 object: obj_x, obj_y (10-bit, top-left), vel (3-bit).
REQ-012 SHALL implement states ESPERA, CAYENDO, ATRAPADO, PERDIDO, FIN.
REQ-013 ESPERA: 5-bit frame counter increments per tick; on the tick it equals 29, load obj_x = 56 + lfsr[8:0] (range 56..567), obj_y = 0, counter = 0, go CAYENDO.
REQ-014 CAYENDO, per tick: y_sig = obj_y + vel; if obj_y < 431 and y_sig >= 431 and overlap, set obj_y = 431, go ATRAPADO.
REQ-015 Overlap SHALL be (obj_x + 15 >= pos_x_canasta) && (obj_x <= pos_x_canasta + 90), computed in 11 bits.
REQ-016 CAYENDO: else if y_sig >= 480, go PERDIDO; else obj_y = y_sig.
REQ-017 ATRAPADO (one clk): atrapado = 1; puntaje += 1, saturating at 255; if new puntaje[1:0] == 0 and vel < 7, vel += 1; go ESPERA.
REQ-018 PERDIDO (one clk): vidas -= 1; go FIN if new vidas == 0, else ESPERA.
REQ-019 FIN: absorbing until reset; fin_juego = 1; pintar_objeto = 0; puntaje, vidas frozen.
REQ-020 pintar_objeto SHALL be 1 only in CAYENDO or ATRAPADO, when obj_x <= pixel_x <= obj_x+15 and obj_y <= pixel_y <= obj_y+15; combinational from registered state.
REQ-021 lfsr SHALL be 10-bit Fibonacci (taps 10,7), advancing every clk regardless of state.
REQ-022 Catch and loss SHALL be mutually exclusive within a frame; a catch is evaluated only on the crossing tick, never afterwards.
REQ-023 pos_x_canasta SHALL be sampled only on the crossing tick; changes at other times have no effect.

Reset
REQ-024 Reset SHALL dominate every other event, including a coincident tick.
REQ-025 Reset values: state ESPERA, counter 0, obj_x 0, obj_y 0, vel 2, puntaje 0, vidas 3, atrapado 0, fin_juego 0, lfsr 10'h1A5.
REQ-026 Reset asserted mid-fall SHALL remove the object from the next clk on (pintar_objeto = 0).

Structure
REQ-027 Shared package SHALL hold MAX_X 640, MAX_Y 480, TAMANIO_CANASTA 90, TAMANIO_CANASTA_Y 32, Y_CANASTA 447, FILA_REFRESCO 481, TAMANIO_OBJETO 16, state encodings.
REQ-028 The LFSR SHALL be a separate sub-module lfsr_aleatorio (clk, reset, 10-bit out).
REQ-029 Single registered FSM plus next-state combinational block; no derived clocks.

Verification
REQ-030 Reset, then 30 ticks -> CAYENDO with obj_y 0, obj_x in 56..567, vel 2.
REQ-031 obj_x 300, pos_x_canasta 272, fall -> on the tick obj_y crosses 431: atrapado one clk, puntaje 1, vidas 3, back to ESPERA.
REQ-032 pos_x_canasta 0, obj_x 500 -> object continues past 431, PERDIDO when y_sig >= 480, vidas 3->2, puntaje unchanged.
REQ-033 Four consecutive catches -> vel 2->3 after the 4th; 20 catches -> vel saturates at 7.
REQ-034 Three misses -> vidas 0, fin_juego 1, pintar_objeto 0 thereafter; further ticks change nothing until reset.
REQ-035 Edge overlap: obj_x = pos_x_canasta+90 -> catch; obj_x = pos_x_canasta+91 -> miss; obj_x+15 = pos_x_canasta-1 -> miss.
